// File: rtl/spart_bus_ctrl.sv
// SPART bus master: programs the baud divisor, then services RX reads and arbitrated TX writes.
// Optional BR_CFG_TRACK_EN: reprogram the divisor whenever br_cfg changes while idle.
module spart_bus_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic [1:0] tx_req,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] tx_gnt,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cfg_done,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_RD,
    TX_WR,
    SETTLE
  } state_e;

  state_e     state_q;
  logic [1:0] br_q;
  logic [7:0] dout_q;
  logic       iocs_q;
  logic       iorw_q;
  logic [1:0] ioaddr_q;
  logic [1:0] gnt_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       cfg_done_q;
  logic       prio_q;
  logic [1:0] gnt_d;
  logic       br_chg;

  function automatic logic [7:0] div_lo(input logic [1:0] sel);
    logic [7:0] v;
    unique case (sel)
      2'b00: v = 8'h15;
      2'b01: v = 8'h8A;
      2'b10: v = 8'h45;
      2'b11: v = 8'hA2;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] div_hi(input logic [1:0] sel);
    logic [7:0] v;
    unique case (sel)
      2'b00: v = 8'h05;
      2'b01: v = 8'h02;
      2'b10: v = 8'h01;
      2'b11: v = 8'h00;
    endcase
    return v;
  endfunction

  // prio_q names the client that wins a tie
  always_comb begin
    gnt_d = 2'b00;
    if (tx_req == 2'b11)
      gnt_d = prio_q ? 2'b10 : 2'b01;
    else
      gnt_d = tx_req;
  end

`ifdef BR_CFG_TRACK_EN
  assign br_chg = (br_cfg != br_q);
`else
  assign br_chg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CFG_LO;
      br_q       <= 2'b00;
      dout_q     <= 8'h00;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= 2'b00;
      gnt_q      <= 2'b00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      cfg_done_q <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      gnt_q      <= 2'b00;
      rx_valid_q <= 1'b0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= 2'b00;
      unique case (state_q)
        CFG_LO: begin
          br_q     <= br_cfg;
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b10;
          dout_q   <= div_lo(br_cfg);
          state_q  <= CFG_HI;
        end
        CFG_HI: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b11;
          dout_q   <= div_hi(br_q);
          state_q  <= IDLE;
        end
        IDLE: begin
          if (!cfg_done_q) begin
            cfg_done_q <= 1'b1;
          end else if (br_chg) begin
            cfg_done_q <= 1'b0;
            state_q    <= CFG_LO;
          end else if (rda) begin
            iocs_q  <= 1'b1;
            state_q <= RX_RD;
          end else if (tbr && (tx_req != 2'b00)) begin
            iocs_q  <= 1'b1;
            iorw_q  <= 1'b0;
            dout_q  <= gnt_d[1] ? tx_data1 : tx_data0;
            gnt_q   <= gnt_d;
            prio_q  <= gnt_d[0];
            state_q <= TX_WR;
          end
        end
        RX_RD: begin
          rx_data_q  <= databus;
          rx_valid_q <= 1'b1;
          state_q    <= SETTLE;
        end
        TX_WR:   state_q <= SETTLE;
        SETTLE:  state_q <= IDLE;
        default: state_q <= CFG_LO;
      endcase
    end
  end

  assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign tx_gnt   = gnt_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: doc/spart_bus_ctrl.md
SPART_BUS_CTRL -- requirements
Module: spart_bus_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port clk  input  1  100 MHz system clock; every register samples on its rising edge.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-005 Port tx_req  input  2  per-client transmit request; client must hold it high until granted.
REQ-006 Port tx_data0 / tx_data1  input  8 each  client 0 / client 1 transmit byte; must be stable while tx_req is high.
REQ-007 Port tx_gnt  output  2  one-hot, one-cycle pulse; the granted byte is written in this cycle.
REQ-008 Port rx_data  output  8  last byte read from the SPART.
REQ-009 Port rx_valid  output  1  one-cycle pulse; rx_data is new.
REQ-010 Port cfg_done  output  1  high once the divisor is programmed.
REQ-011 Port iocs  output  1  SPART chip select.
REQ-012 Port iorw  output  1  1=read, 0=write.
REQ-013 Port ioaddr  output  2  00=TX/RX buffer, 01=status, 10=divisor low, 11=divisor high.
REQ-014 Port databus  inout  8  driven only when iocs=1 and iorw=0; high-Z otherwise.
REQ-015 Port rda  input  1  SPART receive data available.
REQ-016 Port tbr  input  1  SPART transmit buffer ready.

Function
REQ-017 The state machine SHALL have states CFG_LO, CFG_HI, IDLE, RX_RD, TX_WR and SETTLE.
REQ-018 CFG_LO SHALL latch br_cfg and write the divisor low byte (ioaddr=10) for 1 cycle, then go to CFG_HI.
REQ-019 CFG_HI SHALL write the divisor high byte (ioaddr=11) for 1 cycle, then go to IDLE; cfg_done becomes 1 on IDLE entry.
REQ-020 Divisor values SHALL be: 4800 -> 0x0515, 9600 -> 0x028A, 19200 -> 0x0145, 38400 -> 0x00A2.
REQ-021 In IDLE, rda=1 SHALL select RX_RD ahead of any transmit.
REQ-022 In IDLE, with rda=0, tbr=1 and any tx_req bit set, the block SHALL go to TX_WR.
REQ-023 RX_RD SHALL be 1 cycle with iocs=1, iorw=1, ioaddr=00; databus is registered into rx_data at the end of that cycle, and rx_valid pulses in the following cycle.
REQ-024 TX_WR SHALL be 1 cycle with iocs=1, iorw=0, ioaddr=00, databus=the granted client's byte, and the matching tx_gnt bit high.
REQ-025 Arbitration SHALL be round-robin: when both clients request, the client not granted last wins; after reset, client 0 has priority.
REQ-026 A lone requester SHALL be granted regardless of the round-robin pointer; the pointer updates only on a grant.
REQ-027 Every RX_RD or TX_WR SHALL be followed by one SETTLE cycle (iocs=0) before returning to IDLE, so rda/tbr can update.
REQ-028 With tbr=0 the block SHALL issue no write; requests wait with tx_gnt=0.
REQ-029 While cfg_done=0, tx_req SHALL be ignored and rda SHALL not be serviced.
REQ-030 Outside bus-access states, iocs SHALL be 0, iorw SHALL be 1, ioaddr SHALL be 00, and databus SHALL be high-Z.

Reset
REQ-031 rst=1 SHALL force the following values on the next edge: state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus high-Z, tx_gnt=00, rx_valid=0, rx_data=0x00, cfg_done=0, round-robin pointer=client 0.
REQ-032 Reset asserted mid-access SHALL abort the access, with no grant or rx_valid issued, and restart configuration in the cycle after rst falls.

Configuration
REQ-033 Macro BR_CFG_TRACK_EN defined: in IDLE, a change of br_cfg from the latched value SHALL clear cfg_done and go to CFG_LO, reprogramming the divisor; an RX_RD or TX_WR in progress completes first.
REQ-034 Macro BR_CFG_TRACK_EN undefined: br_cfg SHALL be sampled only in the CFG_LO pass after reset, and later changes have no effect.

Verification
REQ-035 Reset release with br_cfg=01 -> cycle 1 writes 0x8A to addr 10, cycle 2 writes 0x02 to addr 11, cycle 3 cfg_done=1.
REQ-036 tbr=1, tx_req=11, tx_data0=0x41, tx_data1=0x42, held -> writes 0x41 (tx_gnt=01), SETTLE, then 0x42 (tx_gnt=10); no back-to-back accesses.
REQ-037 rda=1 and tx_req=01 in the same IDLE cycle, SPART drives 0x5A -> RX_RD first, rx_data=0x5A with a rx_valid pulse, then the TX write.
REQ-038 tbr=0 for 10 cycles with tx_req=01 -> no iocs and tx_gnt=00 throughout; write occurs within 1 cycle of tbr rising.
REQ-039 rst pulsed during TX_WR -> no tx_gnt completion, outputs at reset values, and a divisor rewrite follows.
REQ-040 BR_CFG_TRACK_EN defined, br_cfg 01->11 in IDLE -> cfg_done falls, 0xA2/0x00 are written, cfg_done rises; with the macro undefined, no bus activity occurs.
